// File: rtl/cordic_bfloat_ln_if.sv
// Request/response bundle for the bfloat16 natural-log unit.
//
// Handshake: the requester raises start for one cycle with a valid operand
// on a. The unit accepts it only while idle and while done is low. busy is
// high from the accepting edge until the edge that raises done. done is a
// one-cycle pulse, and out is valid on that cycle. out then holds until a
// later request completes. The unit captures a on the accepting edge, so a
// may change freely afterwards.
interface cordic_bfloat_ln_if;
  logic        start;
  logic [15:0] a;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (output start, output a, input busy, input done, input out);
  modport slave  (input start, input a, output busy, output done, output out);
endinterface

// File: rtl/cordic_bfloat_ln.sv
// bfloat16 natural logarithm, computed with iterative hyperbolic CORDIC in
// vectoring mode. The operand is split as a = m * 2^e with m in [1,2).
// Starting from x = m+1, y = m-1 and z = 0, driving y to zero leaves
// z = atanh((m-1)/(m+1)) = ln(m)/2. The result is ln(a) = 2z + e*ln2,
// which is then renormalised to bfloat16 with truncation.
module cordic_bfloat_ln #(
  parameter int ITER  = 16,
  parameter int FRAC  = 20,
  parameter int WIDTH = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  cordic_bfloat_ln_if.slave  bus,
  output logic [2:0]         o_dbg_state
);

  localparam int IW = $clog2(ITER + 1);
  localparam int LW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ITER = 3'd1;
  localparam logic [2:0] S_COMB = 3'd2;
  localparam logic [2:0] S_NORM = 3'd3;
  localparam logic [2:0] S_SPEC = 3'd4;

  // ln2 scaled by 2^20 and truncated. The atanh table below uses the same scale.
  localparam logic signed [WIDTH-1:0] LN2 = WIDTH'(726817);

  // atanh(2^-i) scaled by 2^20 and truncated. From i = 7 upward the value equals 2^(20-i).
  function automatic logic signed [WIDTH-1:0] atanh_lut(input logic [IW-1:0] idx);
    case (idx)
      IW'(1):  return WIDTH'(575989);
      IW'(2):  return WIDTH'(267819);
      IW'(3):  return WIDTH'(131761);
      IW'(4):  return WIDTH'(65621);
      IW'(5):  return WIDTH'(32778);
      IW'(6):  return WIDTH'(16385);
      IW'(7):  return WIDTH'(8192);
      IW'(8):  return WIDTH'(4096);
      IW'(9):  return WIDTH'(2048);
      IW'(10): return WIDTH'(1024);
      IW'(11): return WIDTH'(512);
      IW'(12): return WIDTH'(256);
      IW'(13): return WIDTH'(128);
      IW'(14): return WIDTH'(64);
      IW'(15): return WIDTH'(32);
      IW'(16): return WIDTH'(16);
      default: return '0;
    endcase
  endfunction

  // Returns {is_special, result}. A zero or subnormal operand is flushed and gives -inf.
  function automatic logic [16:0] classify(input logic [15:0] v);
    if (v[14:7] == 8'h00) return {1'b1, 16'hFF80};
    if (v[14:7] == 8'hFF) begin
      if ((v[6:0] != 7'd0) || v[15]) return {1'b1, 16'h7FC0};
      return {1'b1, 16'h7F80};
    end
    if (v[15]) return {1'b1, 16'h7FC0};
    if (v == 16'h3F80) return {1'b1, 16'h0000};
    return {1'b0, 16'h0000};
  endfunction

  logic [2:0]              r_state;
  logic signed [WIDTH-1:0] r_x, r_y, r_z, r_r;
  logic signed [8:0]       r_e;
  logic [IW-1:0]           r_iter;
  logic                    r_rep;
  logic [15:0]             r_spec;
  logic                    r_busy, r_done;
  logic [15:0]             r_out;

  logic                    w_accept;
  logic [16:0]             w_class;
  logic signed [WIDTH-1:0] w_one, w_m, w_xs, w_ys, w_t, w_elin;
  logic                    w_hold;
  logic [WIDTH-1:0]        w_mag;
  logic [LW-1:0]           w_lead, w_sh;
  logic [7:0]              w_exp;
  logic [6:0]              w_man;
  logic [15:0]             w_norm_out;

  // A request is taken only from IDLE, and never on the cycle that done is still high.
  assign w_accept = (r_state == S_IDLE) && bus.start && !r_done;
  assign w_class  = classify(bus.a);

  // The mantissa 1.man is placed at the binary point of the fixed-point datapath.
  assign w_one = WIDTH'(1) << FRAC;
  assign w_m   = w_one | (WIDTH'(bus.a[6:0]) << (FRAC - 7));

  // Micro-rotation terms. Indices 4 and 13 run twice so that the hyperbolic iteration converges.
  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_t    = atanh_lut(r_iter);
  assign w_hold = ((r_iter == IW'(4)) || (r_iter == IW'(13))) && !r_rep;

  assign w_elin = $signed({{(WIDTH-9){r_e[8]}}, r_e}) * LN2;

  // Renormalisation: take the magnitude, find its leading one, then keep the next seven bits.
  assign w_mag = r_r[WIDTH-1] ? WIDTH'(-r_r) : r_r;

  // Priority scan for the highest set bit of the magnitude.
  always_comb begin
    w_lead = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (w_mag[k]) w_lead = LW'(k);
    end
  end

  assign w_sh       = LW'(WIDTH - 1) - w_lead;
  assign w_exp      = 8'(127 - FRAC) + 8'(w_lead);
  assign w_man      = 7'((w_mag << w_sh) >> (WIDTH - 8));
  assign w_norm_out = (r_r == '0) ? 16'h0000 : {r_r[WIDTH-1], w_exp, w_man};

  // Control FSM and datapath registers. All state clears at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_r     <= '0;
      r_e     <= '0;
      r_iter  <= '0;
      r_rep   <= 1'b0;
      r_spec  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (w_class[16]) begin
              r_spec  <= w_class[15:0];
              r_state <= S_SPEC;
            end else begin
              r_e     <= $signed({1'b0, bus.a[14:7]}) - 9'sd127;
              r_x     <= w_m + w_one;
              r_y     <= w_m - w_one;
              r_z     <= '0;
              r_iter  <= IW'(1);
              r_rep   <= 1'b0;
              r_state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          if (!r_y[WIDTH-1]) begin
            r_x <= r_x - w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_t;
          end else begin
            r_x <= r_x + w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_t;
          end
          if (w_hold) begin
            r_rep <= 1'b1;
          end else begin
            r_rep <= 1'b0;
            if (r_iter == IW'(ITER)) r_state <= S_COMB;
            else                     r_iter  <= r_iter + IW'(1);
          end
        end
        S_COMB: begin
          r_r     <= (r_z <<< 1) + w_elin;
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_out   <= w_norm_out;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_SPEC: begin
          r_out   <= r_spec;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.out     = r_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cordic_bfloat_ln.sv
// Bench for cordic_bfloat_ln. Results are checked against a real-arithmetic
// ln() model, truncated to bfloat16, with a tolerance of +/-1 ulp.
module tb_cordic_bfloat_ln;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;

  cordic_bfloat_ln_if bus ();

  cordic_bfloat_ln dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Reference: true ln of the decoded operand, truncated to bfloat16.
  function automatic logic [15:0] ref_ln(input logic [15:0] v);
    real m, val, r;
    logic [63:0] b;
    int be;
    m   = 1.0 + real'(v[6:0]) / 128.0;
    val = m * $pow(2.0, real'(int'(v[14:7]) - 127));
    r   = $ln(val);
    if (r == 0.0) return 16'h0000;
    b  = $realtobits(r);
    be = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(be), b[51:45]};
  endfunction

  // Distance in ulps between two same-sign bfloat16 values. Opposite signs count as far apart.
  function automatic int ulp_dist(input logic [15:0] g, input logic [15:0] e);
    int d;
    if (g[15] !== e[15]) return 1000;
    d = int'(g[14:0]) - int'(e[14:0]);
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [15:0] rand_pos_normal();
    logic [15:0] v;
    v = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom_range(0, 127))};
    if (v == 16'h3F80) v = 16'h3F81;
    return v;
  endfunction

  // Driver: sends one request and returns the result and the number of edges until done.
  task automatic run_op(input logic [15:0] v, output logic [15:0] res, output int lat);
    int busy_bad;
    busy_bad = 0;
    lat = -1;
    res = 16'h0000;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    for (int n = 1; n <= 100; n++) begin
      if (bus.busy !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = n;
        res = bus.out;
        break;
      end
    end
    n_cmp++;
    if (lat < 0) begin
      n_err++;
      $display("FAIL timeout a=%h: no done within 100 edges", v);
    end
    n_cmp++;
    if (busy_bad != 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_window a=%h: low_cycles=%0d busy_at_done=%b, required 0 and 0", v, busy_bad, bus.busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse a=%h: done=%b one cycle later, required 0", v, bus.done);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = 16'h0000;
    rst_n     = 1'b0;
    #12;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_values: busy=%b done=%b out=%h, required 0 0 0000", bus.busy, bus.done, bus.out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'h0000) begin
      n_err++;
      $display("FAIL idle_values: busy=%b done=%b out=%h, required 0 0 0000", bus.busy, bus.done, bus.out);
    end
  endtask

  task automatic test_specials();
    logic [15:0] ins [6]  = '{16'h3F80, 16'h0000, 16'h0001, 16'hBF80, 16'h7FC1, 16'h7F80};
    logic [15:0] outs [6] = '{16'h0000, 16'hFF80, 16'hFF80, 16'h7FC0, 16'h7FC0, 16'h7F80};
    logic [15:0] res;
    int lat;
    for (int k = 0; k < 6; k++) begin
      run_op(ins[k], res, lat);
      n_cmp++;
      if (res !== outs[k] || lat != 1) begin
        n_err++;
        $display("FAIL special a=%h: out=%h lat=%0d, required %h lat=1", ins[k], res, lat, outs[k]);
      end
    end
  endtask

  task automatic test_known();
    logic [15:0] ins [4]  = '{16'h4000, 16'h3F00, 16'h402E, 16'h7F7F};
    logic [15:0] outs [4] = '{16'h3F31, 16'hBF31, 16'h3F80, 16'h42B1};
    logic [15:0] res;
    int lat;
    for (int k = 0; k < 4; k++) begin
      run_op(ins[k], res, lat);
      n_cmp++;
      if (ulp_dist(res, outs[k]) > 1 || lat != 20) begin
        n_err++;
        $display("FAIL known a=%h: out=%h lat=%0d, required %h+/-1ulp lat=20", ins[k], res, lat, outs[k]);
      end
    end
  endtask

  task automatic test_busy_restart();
    int n_done, done_edge;
    logic [15:0] res;
    logic probe;
    n_done = 0;
    done_edge = -1;
    res = 16'h0000;
    probe = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h4000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        bus.start = 1'b1;
        bus.a     = 16'h3F00;
      end
      @(posedge clk);
      #1;
      if (n == 5) bus.start = 1'b0;
      if (probe) begin
        probe = 1'b0;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_err++;
          $display("FAIL start_during_done: busy=%b, required 0", bus.busy);
        end
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_edge < 0) begin
          done_edge = n;
          res = bus.out;
          bus.start = 1'b1;
          bus.a = 16'h3F00;
          probe = 1'b1;
        end
      end
    end
    n_cmp++;
    if (n_done != 1 || done_edge != 20 || ulp_dist(res, 16'h3F31) > 1) begin
      n_err++;
      $display("FAIL start_while_busy: dones=%0d edge=%0d out=%h, required 1 20 3F31+/-1ulp", n_done, done_edge, res);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [$];
    logic [15:0] v, res, e;
    int lat;
    for (int k = 0; k < 6; k++) begin
      v = rand_pos_normal();
      exp_q.push_back(ref_ln(v));
      run_op(v, res, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (ulp_dist(res, e) > 1 || lat != 20) begin
        n_err++;
        $display("FAIL back_to_back a=%h: out=%h lat=%0d, required %h+/-1ulp lat=20", v, res, lat, e);
      end
    end
  endtask

  task automatic test_random_sweep();
    logic [15:0] v, res, e;
    int lat;
    for (int k = 0; k < 300; k++) begin
      case (k)
        0:       v = 16'h0080;
        1:       v = 16'h3F7F;
        2:       v = 16'h3F81;
        3:       v = 16'h7F7F;
        default: v = rand_pos_normal();
      endcase
      e = ref_ln(v);
      run_op(v, res, lat);
      n_cmp++;
      if (ulp_dist(res, e) > 1 || lat != 20) begin
        n_err++;
        $display("FAIL sweep a=%h: out=%h lat=%0d, required %h+/-1ulp lat=20", v, res, lat, e);
      end
    end
  endtask

  task automatic test_abort();
    int n_done;
    n_done = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h4000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_clear: busy=%b done=%b out=%h, required 0 0 0000", bus.busy, bus.done, bus.out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done != 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: dones=%0d busy=%b, required 0 0", n_done, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_specials();
    test_known();
    test_busy_restart();
    test_back_to_back();
    test_random_sweep();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_bfloat_ln.md
Name: cordic_bfloat_ln

Overview:
- Iterative hyperbolic CORDIC in vectoring mode. Computes the natural logarithm of a bfloat16 operand and returns a bfloat16 result.
- Inverse companion of the softmax exp unit in Vector_Engine/Softmax. Serves log-softmax and log-sum-exp paths.
- Method:
  - Split the operand as a = m·2^e, with m in [1,2).
  - Drive y toward 0 from x0 = m+1, y0 = m−1, z0 = 0. Then ln m = 2z.
  - Result is ln a = 2z + e·ln2, normalised back to bfloat16.

Parameters:
- ITER, 16: highest CORDIC shift index (i = 1..ITER). Indices 4 and 13 are executed twice, so NI = ITER+2 iteration cycles for ITER ≥ 13.
- FRAC, 20: fractional bits of the internal fixed-point datapath.
- WIDTH, 30: total signed width of the x/y/z registers and the combine adder (sign + 9 integer bits + FRAC).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- a  in  16  bfloat16 operand {sign, exp[7:0], man[6:0]}
- busy  out  1  high from the start-accept edge until done is asserted
- done  out  1  one-cycle pulse; out is valid on this cycle
- out  out  16  bfloat16 ln(a), held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0, done = 0, out = 16'h0000.
  - x, y, z, iteration counter and repeat flag all cleared.
  - Reset mid-operation aborts the computation; no done pulse follows.
- States:
  - IDLE → ITERATE: start = 1 with a non-special operand.
  - IDLE → SPECIAL: start = 1 with a special operand.
  - ITERATE → COMBINE: after NI cycles.
  - COMBINE → NORM: one cycle.
  - NORM → IDLE: one cycle; done = 1 here.
  - SPECIAL → IDLE: one cycle; done = 1 here.
- Start edge (edge 0):
  - Latch e = exp−127 (signed 9 bits) and m = 1.man in fixed point.
  - Load x = m + 1, y = m − 1, z = 0; i = 1; busy = 1.
- Special operands, resolved in SPECIAL, out set at edge 1:
  - exp = 0 (zero or subnormal, flushed) → 16'hFF80 (−inf).
  - sign = 1 with nonzero exp, or NaN → 16'h7FC0.
  - +inf → 16'h7F80.
  - Exactly 1.0 (16'h3F80) → 16'h0000.
- ITERATE, one micro-rotation per cycle (arithmetic shifts):
  - If y ≥ 0: x ← x − (y>>>i), y ← y − (x>>>i), z ← z + T[i].
  - If y < 0: x ← x + (y>>>i), y ← y + (x>>>i), z ← z − T[i].
  - T[i] = atanh(2^−i), truncated to FRAC bits; internal LUT, i = 1..ITER.
  - Repeats: at i = 4 and i = 13 the index is held for one extra cycle via a repeat flag, then incremented.
  - After NI cycles, go to COMBINE.
- COMBINE: r = (z <<< 1) + e·LN2, with LN2 = ln2 truncated to FRAC bits. Signed WIDTH-bit result; |r| < 89, so no overflow.
- NORM:
  - r = 0 → out = 16'h0000.
  - Otherwise: sign = r[MSB]; mag = |r|; p = position of the leading one relative to the binary point.
  - out = {sign, 127+p, next 7 bits below the leading one}, truncated (round toward zero).
  - done = 1 for exactly one cycle; busy falls on the same edge.
- Latency, start edge → done edge:
  - NI+2 edges for normal operands (20 at defaults).
  - 1 edge for special operands.
- Boundary cases:
  - start while busy: ignored; no effect on the in-flight result.
  - start on the same cycle done is high: that cycle is still NORM/SPECIAL, so start is ignored. Restarts take effect from IDLE only.
  - a changing after the start edge has no effect.
- Accuracy: for every normal positive operand, out is within 1 ulp of the truncated true ln(a).

Test Plan:
- Reset then idle: no start applied → busy = 0, done = 0, out = 16'h0000. Assert rst_n low mid-ITERATE → outputs clear immediately, no done pulse follows.
- a = 16'h4000 (2.0) → done at edge 20, out = 16'h3F31 (±1 ulp). a = 16'h3F00 (0.5) → out = 16'hBF31 (±1 ulp).
- a = 16'h402E (2.71875) → out = 16'h3F80 (±1 ulp). a = 16'h7F7F (max normal) → out = 16'h42B1 (±1 ulp).
- Specials, each with done at edge 1:
  - 16'h3F80 → 16'h0000
  - 16'h0000 → 16'hFF80
  - 16'h0001 → 16'hFF80
  - 16'hBF80 → 16'h7FC0
  - 16'h7FC1 → 16'h7FC0
  - 16'h7F80 → 16'h7F80
- Handshake: start = 1 with a = 16'h4000, then start = 1 with a = 16'h3F00 pulsed at edge 5 → single done at edge 20 with 16'h3F31. Back-to-back starts from IDLE each complete correctly.
- Sweep all positive normal bfloat16 values against a reference model → every result within 1 ulp. Exactly one done per accepted start, with busy high throughout.
